boot_rom_mapper: RTL
====================

// Module: boot_rom_mapper
// PURPOSE
//  Sequences CPU reads of 0x0000-0x7FFF: the boot ROM while the boot overlay is active, otherwise the cartridge.
//  - Owns the 0xFF50 boot-disable latch.
//  - Drives the boot ROM enable/address and a req/ack handshake to the cartridge bus.
//  - Returns data to the CPU with a one-cycle ready pulse.
//  - Sits between the CPU bus decoder and boot_rom / cartridge interface.
// PARAMETERS
//  CART_TIMEOUT   16     cycles cart_req may stay unacked before the access is aborted
//  TIMEOUT_DATA   8'hFF  read data returned on a cartridge timeout
//  BOOT_AW        8      boot ROM address width; overlay covers 0x0000..2**BOOT_AW-1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  cpu_addr     in   16  CPU address, valid with strobe
//  cpu_rd       in   1   read strobe, one-cycle pulse
//  cpu_wr       in   1   write strobe, one-cycle pulse
//  cpu_wdata    in   8   write data
//  cpu_rdata    out  8   read data, valid while cpu_ready=1
//  cpu_ready    out  1   one-cycle completion pulse
//  boot_en      out  1   boot ROM output enable
//  boot_addr    out  8   boot ROM address
//  boot_data    in   8   boot ROM data (tri-stated when boot_en=0)
//  cart_req     out  1   cartridge access request, held until ack or timeout
//  cart_we      out  1   1=write, 0=read; valid while cart_req=1
//  cart_addr    out  16  cartridge address; valid while cart_req=1
//  cart_wdata   out  8   cartridge write data
//  cart_ack     in   1   cartridge completion, sampled on clk
//  cart_rdata   in   8   cartridge read data, valid with cart_ack
//  boot_active  out  1   1 = overlay mapped
// BEHAVIOUR
//  Reset values
//   - State=IDLE, boot_active=1; all other outputs 0.
//   - Reset mid-access drops cart_req immediately; no ready is issued.
//  Decode (IDLE only; strobes in other states are ignored, not queued)
//   - rd & boot_active & addr<0x0100 -> BOOT_RD.
//   - rd & addr<=0x7FFF otherwise -> CART (read).
//   - wr & addr<=0x7FFF -> CART (write). Writes go to the cart even under the overlay (MBC registers).
//   - wr & addr==0xFF50 -> LOCK.
//   - Any other address: no action, no ready (another slave responds).
//   - cpu_rd & cpu_wr together: write taken, read dropped.
//  BOOT_RD (1 cycle)
//   - boot_en=1, boot_addr=cpu_addr[7:0] latched at the strobe.
//   - boot_data is registered into cpu_rdata.
//   - Next cycle: cpu_ready=1, state=IDLE. Strobe at N -> ready at N+2.
//  CART
//   - From N+1: cart_req=1 with addr/we/wdata latched.
//   - A timeout counter runs from 0, +1 per unacked cycle.
//   - Ack sampled at cycle M: cart_req=0 at M+1; cpu_ready=1 at M+1; cpu_rdata=cart_rdata (reads).
//   - Counter reaches CART_TIMEOUT-1 without ack: cart_req drops; next cycle cpu_ready=1, cpu_rdata=TIMEOUT_DATA.
//   - Ack in the same cycle as the timeout: the ack wins.
//  LOCK (1 cycle)
//   - Nonzero cpu_wdata: boot_active<=0, sticky until rst.
//   - Zero data, or a write after lock: no effect.
//   - cpu_ready at N+2.
//  Ready and data rules
//   - A new strobe may be accepted in the same cycle as cpu_ready (IDLE).
//   - cpu_rdata holds its last value outside cpu_ready.
//   - boot_en is never 1 while boot_active=0.
// CONFIGURATION
//  BOOT_ROM_LOCK_READBACK_EN
//   - Defined: a read of 0xFF50 goes through BOOT_RD timing (ready at N+2) without boot_en.
//     Returned data is {7'h7F, ~boot_active}.
//   - Undefined: 0xFF50 reads are not decoded (no ready); the latch is write-only.
// TESTING
//  - rst, then rd 0x0000 -> boot_en=1 at N+1, boot_addr=0x00; cpu_ready at N+2 with rdata=boot_data (0x31).
//  - rd 0x0104 under the overlay -> cart_req at N+1, addr=0x0104, we=0.
//    Ack after 3 cycles with 0xCE -> ready 1 cycle after ack, rdata=0xCE.
//  - wr 0xFF50 data 0x00 -> boot_active stays 1.
//    wr 0xFF50 data 0x01 -> boot_active=0 at N+2.
//    Then rd 0x0000 -> cart access, boot_en stays 0.
//  - CART_TIMEOUT=16, cart_ack tied 0, rd 0x4000 -> cart_req high 16 cycles, ready next cycle, rdata=0xFF.
//  - Assert rst while cart_req=1 -> cart_req=0 asynchronously, no ready, boot_active=1 after release.
//  - Readback macro defined -> rd 0xFF50 returns 0xFE before lock, 0xFF after.
//    Undefined -> no ready. Also check cpu_rd+cpu_wr to 0x2000 -> cart_we=1.

Source files
------------

// File: rtl/boot_rom_mapper_if.sv
// Bus bundle between the CPU decoder, boot ROM, cartridge port and boot_rom_mapper.
// slave = the mapper itself, master = the surrounding system (CPU, ROM, cartridge).
interface boot_rom_mapper_if #(
  parameter int BOOT_AW = 8
);
  logic [15:0]        cpu_addr;
  logic               cpu_rd;
  logic               cpu_wr;
  logic [7:0]         cpu_wdata;
  logic [7:0]         cpu_rdata;
  logic               cpu_ready;
  logic               boot_en;
  logic [BOOT_AW-1:0] boot_addr;
  logic [7:0]         boot_data;
  logic               cart_req;
  logic               cart_we;
  logic [15:0]        cart_addr;
  logic [7:0]         cart_wdata;
  logic               cart_ack;
  logic [7:0]         cart_rdata;
  logic               boot_active;

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, boot_data, cart_ack, cart_rdata,
    output cpu_rdata, cpu_ready, boot_en, boot_addr, cart_req, cart_we,
           cart_addr, cart_wdata, boot_active
  );

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, boot_data, cart_ack, cart_rdata,
    input  cpu_rdata, cpu_ready, boot_en, boot_addr, cart_req, cart_we,
           cart_addr, cart_wdata, boot_active
  );
endinterface

// File: rtl/boot_rom_mapper.sv
// Maps CPU reads of 0x0000-0x7FFF to the boot ROM overlay or the cartridge, and owns the 0xFF50 latch.
// Optional BOOT_ROM_LOCK_READBACK_EN: makes 0xFF50 readable as {7'h7F, ~boot_active}.
module boot_rom_mapper #(
  parameter int         CART_TIMEOUT = 16,
  parameter logic [7:0] TIMEOUT_DATA = 8'hFF,
  parameter int         BOOT_AW      = 8
) (
  input logic              clk,
  input logic              rst,
  boot_rom_mapper_if.slave bus
);

  localparam int            CW       = (CART_TIMEOUT > 1) ? $clog2(CART_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CART_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    BOOT_RD,
    CART,
    LOCK,
    LOCK_RD
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               boot_en_q, boot_en_d;
  logic [BOOT_AW-1:0] boot_addr_q, boot_addr_d;
  logic               cart_req_q, cart_req_d;
  logic               cart_we_q, cart_we_d;
  logic [15:0]        cart_addr_q, cart_addr_d;
  logic [7:0]         cart_wdata_q, cart_wdata_d;
  logic               boot_active_q, boot_active_d;
  logic               lock_set_q, lock_set_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic in_cart_space;
  logic in_boot_space;
  logic is_lock_addr;

  assign in_cart_space = ~bus.cpu_addr[15];
  assign in_boot_space = (bus.cpu_addr >> BOOT_AW) == 16'd0;
  assign is_lock_addr  = bus.cpu_addr == 16'hFF50;

  always_comb begin
    state_d       = state_q;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_ready_d   = 1'b0;
    boot_en_d     = boot_en_q;
    boot_addr_d   = boot_addr_q;
    cart_req_d    = cart_req_q;
    cart_we_d     = cart_we_q;
    cart_addr_d   = cart_addr_q;
    cart_wdata_d  = cart_wdata_q;
    boot_active_d = boot_active_q;
    lock_set_d    = lock_set_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        // Writes take priority over a simultaneous read; unmapped addresses belong to other slaves.
        if (bus.cpu_wr) begin
          if (in_cart_space) begin
            state_d      = CART;
            cart_req_d   = 1'b1;
            cart_we_d    = 1'b1;
            cart_addr_d  = bus.cpu_addr;
            cart_wdata_d = bus.cpu_wdata;
            cnt_d        = '0;
          end else if (is_lock_addr) begin
            state_d    = LOCK;
            lock_set_d = |bus.cpu_wdata;
          end
        end else if (bus.cpu_rd) begin
          if (boot_active_q && in_boot_space) begin
            state_d     = BOOT_RD;
            boot_en_d   = 1'b1;
            boot_addr_d = bus.cpu_addr[BOOT_AW-1:0];
          end else if (in_cart_space) begin
            state_d      = CART;
            cart_req_d   = 1'b1;
            cart_we_d    = 1'b0;
            cart_addr_d  = bus.cpu_addr;
            cart_wdata_d = bus.cpu_wdata;
            cnt_d        = '0;
          end
`ifdef BOOT_ROM_LOCK_READBACK_EN
          else if (is_lock_addr) begin
            state_d = LOCK_RD;
          end
`endif
        end
      end

      BOOT_RD: begin
        cpu_rdata_d = bus.boot_data;
        cpu_ready_d = 1'b1;
        boot_en_d   = 1'b0;
        state_d     = IDLE;
      end

      CART: begin
        // An ack on the final counted cycle still completes normally.
        if (bus.cart_ack) begin
          cart_req_d  = 1'b0;
          cpu_ready_d = 1'b1;
          if (!cart_we_q) begin
            cpu_rdata_d = bus.cart_rdata;
          end
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cart_req_d  = 1'b0;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = TIMEOUT_DATA;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      LOCK: begin
        if (lock_set_q) begin
          boot_active_d = 1'b0;
        end
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end

      LOCK_RD: begin
        cpu_rdata_d = {7'h7F, ~boot_active_q};
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cpu_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      boot_en_q     <= 1'b0;
      boot_addr_q   <= '0;
      cart_req_q    <= 1'b0;
      cart_we_q     <= 1'b0;
      cart_addr_q   <= '0;
      cart_wdata_q  <= '0;
      boot_active_q <= 1'b1;
      lock_set_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ready_q   <= cpu_ready_d;
      boot_en_q     <= boot_en_d;
      boot_addr_q   <= boot_addr_d;
      cart_req_q    <= cart_req_d;
      cart_we_q     <= cart_we_d;
      cart_addr_q   <= cart_addr_d;
      cart_wdata_q  <= cart_wdata_d;
      boot_active_q <= boot_active_d;
      lock_set_q    <= lock_set_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.cpu_ready   = cpu_ready_q;
  assign bus.boot_en     = boot_en_q;
  assign bus.boot_addr   = boot_addr_q;
  assign bus.cart_req    = cart_req_q;
  assign bus.cart_we     = cart_we_q;
  assign bus.cart_addr   = cart_addr_q;
  assign bus.cart_wdata  = cart_wdata_q;
  assign bus.boot_active = boot_active_q;

endmodule
